pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the openMIPS core, generalising the ID/EX latch so one module can serve IF/ID, ID/EX, EX/MEM and MEM/WB. It captures an upstream payload every cycle and obeys the six-bit `stall` vector from `ctrl`. It supports a synchronous `flush` for exceptions, and a split payload: one part is cleared on a bubble and the other is held across a bubble, as the delay-slot and link fields are. Optional performance counters report stall, bubble and flush cycles.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_sat_cnt.sv | 35 +++
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: stall polarity, stage indices, action decode.
// Used by pipe_stage_reg and its counter sub-module.
package pipe_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit positions in the ctrl stall vector.
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    localparam int IDEX_DATA_W = 64;
    localparam int IDEX_KEEP_W = 33;
    localparam int PERF_CNT_W  = 32;

    typedef enum logic [2:0] {
        ACT_RST,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_ADV
    } pipe_act_t;

    // A stopped downstream stage wins over an upstream bubble, including the
    // non-monotonic up=0/dn=1 case, so the stage never overruns its consumer.
    function automatic pipe_act_t pipe_decode(input logic rst, input logic flush,
                                              input logic up, input logic dn);
        if (rst)        return ACT_RST;
        if (flush)      return ACT_FLUSH;
        if (dn == Stop) return ACT_HOLD;
        if (up == Stop) return ACT_BUBBLE;
        return ACT_ADV;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with synchronous reset and clear; clear beats increment.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall/bubble/flush handling.
// Define PIPE_PERF_CNT_EN to add perf_clr and the stall/bubble/flush counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = IDEX_DATA_W,
    parameter int                KEEP_W  = IDEX_KEEP_W,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter int                STAGE   = STG_ID,
    parameter int                CNT_W   = PERF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep
`ifdef PIPE_PERF_CNT_EN
    ,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    pipe_act_t         act;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;

    // Only two stall bits matter here; the rest belong to other stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    always_comb begin
        act     = pipe_decode(rst, flush, stall[STAGE], stall[STAGE+1]);
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        case (act)
            ACT_RST, ACT_FLUSH: begin
                valid_d = 1'b0;
                data_d  = NOP_VAL;
                keep_d  = '0;
            end
            // Delay-slot and link fields survive the bubble.
            ACT_BUBBLE: begin
                valid_d = 1'b0;
                data_d  = NOP_VAL;
            end
            ACT_ADV: begin
                valid_d = in_valid;
                data_d  = in_data;
                keep_d  = in_keep;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VAL;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;

`ifdef PIPE_PERF_CNT_EN
    logic inc_hold, inc_bubble, inc_flush;

    assign inc_hold   = (act == ACT_HOLD);
    assign inc_bubble = (act == ACT_BUBBLE);
    assign inc_flush  = (act == ACT_FLUSH);

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .inc (inc_hold),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .inc (inc_bubble),
        .cnt (bubble_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (perf_clr),
        .inc (inc_flush),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed plan followed by random traffic
// compared cycle by cycle against a behavioural model.
module tb_pipe_stage_reg;

    localparam int                DATA_W  = 64;
    localparam int                KEEP_W  = 33;
    localparam logic [DATA_W-1:0] NOP_VAL = 64'h0000_0000_DEAD_0000;
    localparam int                STAGE   = 2;
    localparam int                CNT_W   = 4;
    localparam int                CMAX    = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [KEEP_W-1:0] in_keep;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [KEEP_W-1:0] out_keep;
    logic              perf_clr;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;
`endif

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W),
        .NOP_VAL(NOP_VAL),
        .STAGE  (STAGE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_clr  (perf_clr),
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [KEEP_W-1:0] m_keep;
    int                m_stall_c, m_bub_c, m_fl_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // Apply one cycle of inputs, advance the model by the spec's rules, compare.
    task automatic step(input logic r, input logic f, input logic [5:0] s,
                        input logic v, input logic [DATA_W-1:0] d,
                        input logic [KEEP_W-1:0] k, input logic c);
        bit up, dn;
        rst = r; flush = f; stall = s; in_valid = v; in_data = d; in_keep = k; perf_clr = c;
        up = s[STAGE];
        dn = s[STAGE+1];
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = NOP_VAL; m_keep = '0;
            m_stall_c = 0; m_bub_c = 0; m_fl_c = 0;
        end else begin
            if (f) begin
                m_valid = 0; m_data = NOP_VAL; m_keep = '0;
                m_fl_c = sat_inc(m_fl_c);
            end else if (dn) begin
                m_stall_c = sat_inc(m_stall_c);
            end else if (up) begin
                m_valid = 0; m_data = NOP_VAL;
                m_bub_c = sat_inc(m_bub_c);
            end else begin
                m_valid = v; m_data = d; m_keep = k;
            end
            if (c) begin
                m_stall_c = 0; m_bub_c = 0; m_fl_c = 0;
            end
        end
        #1;
        chk("valid", 64'(out_valid), 64'(m_valid));
        chk("data",  out_data,       m_data);
        chk("keep",  64'(out_keep),  64'(m_keep));
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt",  64'(stall_cnt),  64'(m_stall_c));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub_c));
        chk("flush_cnt",  64'(flush_cnt),  64'(m_fl_c));
`endif
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [KEEP_W-1:0] rnd_keep();
        return {1'($urandom), 32'($urandom)};
    endfunction

    initial begin
        logic [5:0] s;
        m_valid = 0; m_data = NOP_VAL; m_keep = '0;
        m_stall_c = 0; m_bub_c = 0; m_fl_c = 0;

        // Reset state
        step(1, 0, 6'b0, 1, rnd_data(), rnd_keep(), 0);
        step(1, 0, 6'b0, 1, rnd_data(), rnd_keep(), 0);
        chk("rst_data", out_data, NOP_VAL);

        // 1: advance
        step(0, 0, 6'b000000, 1, 64'h0000_0021_1234_5678, 33'h1_0040_0008, 0);
        chk("adv_data", out_data, 64'h0000_0021_1234_5678);
        // 2: bubble keeps the held payload
        step(0, 0, 6'b000111, 1, rnd_data(), rnd_keep(), 0);
        chk("bub_keep", 64'(out_keep), 64'h1_0040_0008);
        // 3: hold with changing inputs
        for (int i = 0; i < 3; i++) step(0, 0, 6'b001111, 1, rnd_data(), rnd_keep(), 0);
        // 4: flush beats hold
        step(0, 1, 6'b001111, 1, rnd_data(), rnd_keep(), 0);
        chk("flush_keep", 64'(out_keep), 64'h0);
        // 5: non-monotonic stall holds
        step(0, 0, 6'b000000, 1, 64'h0123_4567_89AB_CDEF, 33'h0_DEAD_BEEF, 0);
        step(0, 0, 6'b001000, 0, rnd_data(), rnd_keep(), 0);
        chk("nm_hold", out_data, 64'h0123_4567_89AB_CDEF);
        // 6: saturation, then clear during hold
        for (int i = 0; i < CMAX + 4; i++) step(0, 0, 6'b001111, 1, rnd_data(), rnd_keep(), 0);
        step(0, 0, 6'b001111, 1, rnd_data(), rnd_keep(), 1);
        // Reset mid-bubble, then normal advance
        step(0, 0, 6'b000111, 1, rnd_data(), rnd_keep(), 0);
        step(1, 0, 6'b000111, 1, rnd_data(), rnd_keep(), 0);
        step(0, 0, 6'b000000, 1, rnd_data(), rnd_keep(), 0);

        // Random traffic, weighted toward the interesting stall bits
        for (int i = 0; i < 600; i++) begin
            s = 6'($urandom);
            if ($urandom_range(0, 2) == 0) s[STAGE+1] = 1'b0;
            if ($urandom_range(0, 2) == 0) s[STAGE]   = 1'b0;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, s,
                 1'($urandom), rnd_data(), rnd_keep(), $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
